dmem_bus_ctrl: RTL and testbench
================================

# dmem_bus_ctrl

Parametrised data-memory subsystem for the single-cycle and future multi-cycle MIPS cores. Sits between the CPU data port and storage, replacing the fixed word-only `(addr - 0x10010000) >> 2` mapping. Provides:
- byte/half/word access with sign or zero extension;
- a request/ready handshake with configurable wait states;
- an MMIO window (LEDs, switches, cycle and fault counters);
- fault reporting for unmapped, misaligned or illegal accesses.

## Interface
Parameters:
- DMEM_BASE, 32'h10010000, byte base address of data RAM
- DMEM_WORDS, 1024, RAM depth in 32-bit words (power of two)
- MMIO_BASE, 32'h10020000, byte base of 16-byte MMIO window
- WAIT_CYCLES, 0, extra wait states per mapped access (0-15)

Ports:
- clk_in  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  access request, sampled in IDLE only
- we  in  1  1 = store, 0 = load
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- uns  in  1  loads: 1 = zero-extend, 0 = sign-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rdata  out  32  load result, valid only while ready=1
- ready  out  1  one-cycle completion pulse
- fault  out  1  qualifies ready: access rejected
- led  out  16  LED register
- sw  in  16  asynchronous switch inputs
- irq_fault  out  1  sticky; set on any fault, cleared by write to MMIO+0xC

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE + req=1: capture we/size/uns/addr/wdata, then decode.
  - Decode passes: go to WAIT if WAIT_CYCLES>0, else RESP.
  - Decode fails: go to RESP with fault latched.
- Input changes after capture are ignored.
- WAIT: counter loads WAIT_CYCLES-1 and decrements. Leave for RESP at 0.
- Memory operation executes on the edge entering RESP:
  - loads register rdata;
  - stores update RAM or MMIO.
- RESP: ready=1 for exactly one cycle, then IDLE. Fault paths skip WAIT.
- RAM decode:
  - off = addr - DMEM_BASE, unsigned 32-bit subtract.
  - Hit iff off < DMEM_WORDS*4.
  - Word index = off[log2(DMEM_WORDS)+1:2].
- MMIO decode (hit iff addr[31:4] == MMIO_BASE[31:4]):
  - +0x0 LED: RW, low 16 bits; reads zero-extended.
  - +0x4 SW: RO, 2-flop synchronised switches, zero-extended.
  - +0x8 CYCLE: RO, free-running 32-bit counter, wraps.
  - +0xC FAULTS: saturating 32-bit count of faulted requests. Write of any value clears irq_fault; the count is unchanged.
- MMIO writes to RO registers are silently dropped (no fault).
- Fault conditions, checked in order:
  - size=3;
  - misaligned: half with addr[0]=1, word with addr[1:0]≠0;
  - MMIO access with size≠2;
  - neither region hit.
- On fault: no state change except FAULTS++ (saturates at 0xFFFFFFFF) and irq_fault=1. rdata=0.
- Little-endian lanes, selected by addr[1:0].
  - Byte store writes one lane; half store writes lanes {1,0} or {3,2}.
  - Loads extract the lane(s), then extend per uns.
- RAM contents are not affected by reset.

## Timing
- Reset values:
  - state IDLE; rdata 0, ready 0, fault 0;
  - led 0, irq_fault 0;
  - CYCLE 0, FAULTS 0, sync flops 0.
- Latency, counted from the accepting edge:
  - ready asserts WAIT_CYCLES+1 cycles later (fault: 1 cycle).
  - Throughput: one access per WAIT_CYCLES+2 cycles.
- A req held high through RESP is not re-accepted in RESP. It is accepted again in the following IDLE cycle.
- A store is visible to a load accepted in the next IDLE cycle.
- Reset asserted mid-access returns to IDLE immediately. A store not yet at the RESP edge is not committed.
- SW reads reflect inputs 2-3 cycles old.
- CYCLE read returns the value at the RESP-entry edge.
- Fault at FAULTS saturation: count stays 0xFFFFFFFF, irq_fault still sets.

## Test plan
- WAIT_CYCLES=0:
  - sw 0x12345678 @0x10010004; load word → ready 1 cycle after accept, rdata 0x12345678.
  - lb @0x10010007 → 0x00000012.
  - Store sb 0xFF @0x10010005, then lb → 0xFFFFFFFF; lbu → 0x000000FF.
  - lh @0x10010006 → 0x00001234.
- WAIT_CYCLES=3: load → ready exactly 4 cycles after accept. req held high → second accept 1 cycle after ready.
- Faults, each → ready+fault 1 cycle after accept, irq_fault=1, FAULTS increments:
  - lw @0x10010002;
  - lh @0x10010001;
  - sb @0x10020000;
  - lw @0x00000000;
  - lw @DMEM_BASE+DMEM_WORDS*4.
  - Then write MMIO+0xC → irq_fault=0, FAULTS still 5.
- MMIO:
  - sw 0x0001ABCD to +0x0 → led=0xABCD.
  - sw=0x5A5A; lw +0x4 at least 3 cycles later → 0x00005A5A.
  - Two CYCLE reads 10 cycles apart differ by 10.
- Assert reset during WAIT of a store (WAIT_CYCLES=3). Deassert, reload the address → old value; ready/fault/led return to 0 during reset.

Source files
------------

// File: rtl/dmem_bus_ctrl.sv
// Data-memory controller: byte/half/word RAM, 16-byte MMIO window, and fault reporting behind a req/ready handshake.
// ready pulses WAIT_CYCLES+1 cycles after accept (faults: 1 cycle). New requests are taken only in IDLE.
module dmem_bus_ctrl #(
    parameter logic [31:0] DMEM_BASE   = 32'h10010000,
    parameter int          DMEM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h10020000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        fault,
    output logic [15:0] led,
    input  logic [15:0] sw,
    output logic        irq_fault
);
    localparam int          AW        = $clog2(DMEM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DMEM_WORDS * 4);
    localparam logic [3:0]  WLOAD     = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic        c_we, c_uns, f_lat;
    logic [1:0]  c_size;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  wcnt;
    logic [31:0] cyc, faults;
    logic [15:0] sw_s1, sw_s2;
    logic [31:0] mem [DMEM_WORDS];

    // In IDLE the live inputs are decoded; afterwards only the captured copy is used.
    logic        in_idle, op_we, op_uns;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    assign in_idle  = (state == IDLE);
    assign op_we    = in_idle ? we    : c_we;
    assign op_uns   = in_idle ? uns   : c_uns;
    assign op_size  = in_idle ? size  : c_size;
    assign op_addr  = in_idle ? addr  : c_addr;
    assign op_wdata = in_idle ? wdata : c_wdata;

    logic [31:0] off;
    logic        ram_hit, mmio_hit, misal, dec_fault, accept, exec;
    assign off       = op_addr - DMEM_BASE;
    assign ram_hit   = (off < RAM_BYTES);
    assign mmio_hit  = (op_addr[31:4] == MMIO_BASE[31:4]);
    assign misal     = ((op_size == 2'd1) && op_addr[0]) ||
                       ((op_size == 2'd2) && (op_addr[1:0] != 2'b00));
    assign dec_fault = (op_size == 2'd3) || misal || (mmio_hit && (op_size != 2'd2)) ||
                       !(ram_hit || mmio_hit);
    assign accept    = in_idle && req;
    assign exec      = (accept && !dec_fault && (WAIT_CYCLES == 0)) ||
                       ((state == WAIT) && (wcnt == 4'd0));

    logic [AW-1:0] ram_idx;
    logic [31:0]   ram_word, ram_ld, mmio_rd, wd;
    logic [7:0]    ld_b;
    logic [15:0]   ld_h;
    logic [3:0]    be;
    assign ram_idx  = off[AW+1:2];
    assign ram_word = mem[ram_idx];

    always_comb begin
        ld_b = 8'h00;
        ld_h = 16'h0000;
        ld_b = 8'(ram_word >> {op_addr[1:0], 3'b000});
        ld_h = op_addr[1] ? ram_word[31:16] : ram_word[15:0];
        case (op_size)
            2'd0:    ram_ld = {{24{~op_uns & ld_b[7]}}, ld_b};
            2'd1:    ram_ld = {{16{~op_uns & ld_h[15]}}, ld_h};
            default: ram_ld = ram_word;
        endcase
        case (op_addr[3:2])
            2'd0:    mmio_rd = {16'h0000, led};
            2'd1:    mmio_rd = {16'h0000, sw_s2};
            2'd2:    mmio_rd = cyc;
            default: mmio_rd = faults;
        endcase
        case (op_size)
            2'd0: begin
                be = 4'b0001 << op_addr[1:0];
                wd = {4{op_wdata[7:0]}};
            end
            2'd1: begin
                be = op_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{op_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = op_wdata;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) begin
                if (dec_fault)            state_nxt = RESP;
                else if (WAIT_CYCLES > 0) state_nxt = WAIT;
                else                      state_nxt = RESP;
            end
            WAIT:    if (wcnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign ready = (state == RESP);
    assign fault = ready && f_lat;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            c_we <= 1'b0; c_uns <= 1'b0; c_size <= 2'd0; c_addr <= '0; c_wdata <= '0;
            f_lat <= 1'b0; wcnt <= 4'd0; rdata <= '0; led <= '0; irq_fault <= 1'b0;
            cyc <= '0; faults <= '0; sw_s1 <= '0; sw_s2 <= '0;
        end else begin
            cyc   <= cyc + 32'd1;
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            if (accept) begin
                c_we <= we; c_uns <= uns; c_size <= size; c_addr <= addr; c_wdata <= wdata;
                f_lat <= dec_fault;
                wcnt  <= WLOAD;
                if (dec_fault) begin
                    rdata     <= '0;
                    irq_fault <= 1'b1;
                    if (faults != 32'hFFFF_FFFF) faults <= faults + 32'd1;
                end
            end
            if ((state == WAIT) && (wcnt != 4'd0)) wcnt <= wcnt - 4'd1;
            if (exec) begin
                if (!op_we) begin
                    rdata <= mmio_hit ? mmio_rd : ram_ld;
                end else begin
                    rdata <= '0;
                    // Writes to the read-only SW/CYCLE slots fall through silently.
                    if (mmio_hit && (op_addr[3:2] == 2'd0)) led <= op_wdata[15:0];
                    if (mmio_hit && (op_addr[3:2] == 2'd3)) irq_fault <= 1'b0;
                end
            end
        end
    end

    // RAM has no reset; the reset term keeps a request seen during reset from committing.
    always_ff @(posedge clk_in) begin
        if (exec && op_we && !mmio_hit && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[ram_idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Bench for dmem_bus_ctrl: two instances (0 and 3 wait states) driven with directed and random accesses against a byte-level reference model.
module tb_dmem_bus_ctrl;
    localparam logic [31:0] DB  = 32'h10010000;
    localparam logic [31:0] MB  = 32'h10020000;
    localparam int          WC1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst, req, we, uns, ready, fault, irq;
    logic [1:0]  size  [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [15:0] led   [2];
    logic [15:0] sw    [2];

    dmem_bus_ctrl #(.WAIT_CYCLES(0)) u0 (
        .clk_in(clk), .reset(rst[0]), .req(req[0]), .we(we[0]), .size(size[0]), .uns(uns[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .fault(fault[0]),
        .led(led[0]), .sw(sw[0]), .irq_fault(irq[0]));
    dmem_bus_ctrl #(.WAIT_CYCLES(WC1)) u1 (
        .clk_in(clk), .reset(rst[1]), .req(req[1]), .we(we[1]), .size(size[1]), .uns(uns[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .fault(fault[1]),
        .led(led[1]), .sw(sw[1]), .irq_fault(irq[1]));

    // Reference model: RAM as bytes, plus the architecturally visible registers.
    logic [7:0]  mb   [2][4096];
    logic [15:0] m_led [2];
    logic [31:0] m_fc  [2];
    logic [1:0]  m_irq;
    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, ex, $time);
        end
    endtask

    function automatic int wc(input int d);
        return (d == 0) ? 0 : WC1;
    endfunction

    // One access; called just after a negedge with the DUT idle, returns just after a negedge with it idle.
    task automatic acc(input int d, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] off, ex;
        logic isr, ism, flt, chk_rd;
        int n, lat;
        off = a - DB;
        isr = (off < 32'd4096);
        ism = (a[31:4] == MB[31:4]);
        n   = 1 << sz;
        flt = (sz == 2'd3) || ((a % n) != 0) || (ism && sz != 2'd2) || !(isr || ism);
        ex = 32'h0;
        chk_rd = !w || flt;
        if (!flt && !w && ism) begin
            case (a[3:2])
                2'd0: ex = {16'h0, m_led[d]};
                2'd1: ex = {16'h0, sw[d]};
                2'd2: chk_rd = 1'b0;
                default: ex = m_fc[d];
            endcase
        end else if (!flt && !w) begin
            for (int i = 0; i < n; i++) ex[8*i +: 8] = mb[d][int'(off) + i];
            if (!u && n < 4 && ex[8*n-1])
                for (int i = n; i < 4; i++) ex[8*i +: 8] = 8'hFF;
        end
        req[d] = 1'b1; we[d] = w; size[d] = sz; uns[d] = u; addr[d] = a; wdata[d] = wd;
        @(negedge clk);
        req[d] = 1'b0; addr[d] = $urandom; wdata[d] = $urandom;
        lat = 1;
        while (!ready[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, flt ? 1 : wc(d) + 1);
        chk("fault", {31'h0, fault[d]}, {31'h0, flt});
        if (chk_rd) chk("rdata", rdata[d], ex);
        rd = rdata[d];
        if (flt) begin
            if (m_fc[d] != 32'hFFFF_FFFF) m_fc[d] = m_fc[d] + 1;
            m_irq[d] = 1'b1;
        end else if (w && ism) begin
            if (a[3:2] == 2'd0) m_led[d] = wd[15:0];
            else if (a[3:2] == 2'd3) m_irq[d] = 1'b0;
        end else if (w) begin
            for (int i = 0; i < n; i++) mb[d][int'(off) + i] = wd[8*i +: 8];
        end
        @(negedge clk);
        chk("ready_pulse", {31'h0, ready[d]}, 32'h0);
    endtask

    // Per-cycle check of the persistent outputs whenever the DUT is between responses.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                if (chk_en && !rst[d] && !ready[d]) begin
                    chk("led", {16'h0, led[d]}, {16'h0, m_led[d]});
                    chk("irq", {31'h0, irq[d]}, {31'h0, m_irq[d]});
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic init_window(input int d);
        logic [31:0] r;
        for (int k = 0; k < 16; k++) acc(d, 1'b1, 2'd2, 1'b0, DB + 32'(4*k), $urandom, r);
    endtask

    task automatic rand_run(input int d, input int cnt);
        logic [31:0] a, r;
        int sel;
        for (int k = 0; k < cnt; k++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      a = DB + 32'($urandom_range(0, 63));
            else if (sel == 7) a = MB + 32'($urandom_range(0, 15));
            else if (sel == 8) a = DB + 32'd4096 + 32'($urandom_range(0, 7));
            else               a = $urandom;
            acc(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, $urandom, r);
        end
    endtask

    initial begin
        logic [31:0] r, c1, c2, ex;
        int lat, gap;
        rst = 2'b11; req = 2'b00; we = 2'b00; uns = 2'b00;
        for (int d = 0; d < 2; d++) begin
            size[d] = 2'd0; addr[d] = 32'h0; wdata[d] = 32'h0; sw[d] = 16'h0;
            m_led[d] = 16'h0; m_fc[d] = 32'h0;
        end
        m_irq = 2'b00;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_rdata", rdata[d], 32'h0);
            chk("rst_ready", {31'h0, ready[d]}, 32'h0);
            chk("rst_fault", {31'h0, fault[d]}, 32'h0);
            chk("rst_led", {16'h0, led[d]}, 32'h0);
            chk("rst_irq", {31'h0, irq[d]}, 32'h0);
        end
        rst = 2'b00;
        @(negedge clk);
        chk_en = 1;

        // Zero-wait instance: directed checks.
        init_window(0);
        acc(0, 1'b1, 2'd2, 1'b0, 32'h10010004, 32'h12345678, r);
        acc(0, 1'b0, 2'd2, 1'b0, 32'h10010004, 32'h0, r);  chk("lw", r, 32'h12345678);
        acc(0, 1'b0, 2'd0, 1'b0, 32'h10010007, 32'h0, r);  chk("lb7", r, 32'h00000012);
        acc(0, 1'b1, 2'd0, 1'b0, 32'h10010005, 32'hFF, r);
        acc(0, 1'b0, 2'd0, 1'b0, 32'h10010005, 32'h0, r);  chk("lb5", r, 32'hFFFFFFFF);
        acc(0, 1'b0, 2'd0, 1'b1, 32'h10010005, 32'h0, r);  chk("lbu5", r, 32'h000000FF);
        acc(0, 1'b0, 2'd1, 1'b0, 32'h10010006, 32'h0, r);  chk("lh6", r, 32'h00001234);
        acc(0, 1'b0, 2'd2, 1'b0, MB + 32'hC, 32'h0, r);    chk("faults0", r, 32'h0);
        acc(0, 1'b0, 2'd2, 1'b0, 32'h10010002, 32'h0, r);
        acc(0, 1'b0, 2'd1, 1'b0, 32'h10010001, 32'h0, r);
        acc(0, 1'b1, 2'd0, 1'b0, MB, 32'h55, r);
        acc(0, 1'b0, 2'd2, 1'b0, 32'h00000000, 32'h0, r);
        acc(0, 1'b0, 2'd2, 1'b0, DB + 32'd4096, 32'h0, r);
        chk("irq_set", {31'h0, irq[0]}, 32'h1);
        acc(0, 1'b0, 2'd2, 1'b0, MB + 32'hC, 32'h0, r);    chk("faults5", r, 32'd5);
        acc(0, 1'b1, 2'd2, 1'b0, MB + 32'hC, 32'h0, r);
        chk("irq_clr", {31'h0, irq[0]}, 32'h0);
        acc(0, 1'b0, 2'd2, 1'b0, MB + 32'hC, 32'h0, r);    chk("faults5b", r, 32'd5);
        acc(0, 1'b1, 2'd2, 1'b0, MB, 32'h0001ABCD, r);
        chk("led_abcd", {16'h0, led[0]}, 32'h0000ABCD);
        acc(0, 1'b0, 2'd2, 1'b0, MB, 32'h0, r);            chk("led_rd", r, 32'h0000ABCD);
        sw[0] = 16'h5A5A;
        repeat (3) @(negedge clk);
        acc(0, 1'b0, 2'd2, 1'b0, MB + 32'h4, 32'h0, r);    chk("sw_rd", r, 32'h00005A5A);
        acc(0, 1'b1, 2'd2, 1'b0, MB + 32'h4, 32'hFFFFFFFF, r);
        acc(0, 1'b0, 2'd2, 1'b0, MB + 32'h4, 32'h0, r);    chk("sw_ro", r, 32'h00005A5A);
        acc(0, 1'b0, 2'd2, 1'b0, MB + 32'h8, 32'h0, c1);
        repeat (8) @(negedge clk);
        acc(0, 1'b0, 2'd2, 1'b0, MB + 32'h8, 32'h0, c2);
        chk("cycle_delta", c2 - c1, 32'd10);
        rand_run(0, 300);

        // Three-wait instance.
        init_window(1);
        ex = {mb[1][11], mb[1][10], mb[1][9], mb[1][8]};
        req[1] = 1'b1; we[1] = 1'b0; size[1] = 2'd2; uns[1] = 1'b0; addr[1] = DB + 32'd8;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready[1] && lat < 40);
        chk("hold_lat", lat, 32'd4);
        chk("hold_rd1", rdata[1], ex);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!ready[1] && gap < 40);
        chk("hold_gap", gap, 32'd5);
        chk("hold_rd2", rdata[1], ex);
        req[1] = 1'b0;
        @(negedge clk);
        chk("hold_drop", {31'h0, ready[1]}, 32'h0);
        rand_run(1, 150);

        acc(1, 1'b1, 2'd2, 1'b0, DB + 32'd12, 32'hCAFEF00D, r);
        acc(1, 1'b1, 2'd2, 1'b0, MB, 32'h0000BEEF, r);
        acc(1, 1'b0, 2'd2, 1'b0, 32'h00000000, 32'h0, r);
        req[1] = 1'b1; we[1] = 1'b1; size[1] = 2'd2; addr[1] = DB + 32'd12; wdata[1] = 32'h11111111;
        @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        m_led[1] = 16'h0; m_fc[1] = 32'h0; m_irq[1] = 1'b0;
        #1;
        chk("rstw_ready", {31'h0, ready[1]}, 32'h0);
        chk("rstw_fault", {31'h0, fault[1]}, 32'h0);
        chk("rstw_led", {16'h0, led[1]}, 32'h0);
        chk("rstw_irq", {31'h0, irq[1]}, 32'h0);
        @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);
        acc(1, 1'b0, 2'd2, 1'b0, DB + 32'd12, 32'h0, r);   chk("rst_nocommit", r, 32'hCAFEF00D);
        acc(1, 1'b0, 2'd2, 1'b0, MB + 32'hC, 32'h0, r);    chk("rst_faults", r, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
